// File: rtl/emph_pkg.sv
// Shared constants and types for the pre-/de-emphasis filter pair.
// Both blocks use the same Q15 coefficient, so they stay exact inverses.
package emph_pkg;

    localparam int Q         = 15;
    localparam int COEF_Q15  = 31785;
    localparam int IN_MSB    = 16;
    localparam int OUT_MSB   = 15;
    localparam int FRAME_LEN = 16000;

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    function automatic int cnt_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sat_round.sv
// Rounds a Q15 feedback product, adds the input sample and clamps
// the result to the output width, flagging any clip.
module sat_round
    import emph_pkg::*;
#(
    parameter int I_BW = IN_MSB,
    parameter int O_BW = OUT_MSB,
    parameter int PW   = O_BW + 18
) (
    input  logic signed [PW-1:0] prod,
    input  logic signed [I_BW:0] data_i,
    output logic signed [O_BW:0] data_o,
    output logic                 sat_o
);

    localparam int FW = PW - Q;
    localparam int SW = ((I_BW + 1 > FW) ? I_BW + 1 : FW) + 1;

    localparam logic signed [PW-1:0] HALF = PW'(2 ** (Q - 1));
    localparam logic signed [SW-1:0] MAXV = SW'(2 ** O_BW - 1);
    localparam logic signed [SW-1:0] MINV = SW'(-(2 ** O_BW));

    logic signed [PW-1:0] rnd;
    logic signed [FW-1:0] fb;
    logic signed [SW-1:0] sum;
    logic                 unused_lsb;

    // Round half up, then drop the Q fraction bits.
    assign rnd        = prod + HALF;
    assign fb         = rnd[PW-1:Q];
    assign unused_lsb = ^rnd[Q-1:0];

    assign sum = {{(SW-I_BW-1){data_i[I_BW]}}, data_i}
               + {{(SW-FW){fb[FW-1]}}, fb};

    always_comb begin
        sat_o  = 1'b1;
        data_o = MAXV[O_BW:0];
        if (sum < MINV) begin
            data_o = MINV[O_BW:0];
        end else if (sum <= MAXV) begin
            sat_o  = 1'b0;
            data_o = sum[O_BW:0];
        end
    end

endmodule

// File: rtl/deemphasis.sv
// Frame-aware first-order de-emphasis IIR: y[n] = x[n] + a*y[n-1].
// One-cycle latency, saturating output, history cleared per frame.
module deemphasis
    import emph_pkg::*;
#(
    parameter int I_BW      = IN_MSB,
    parameter int O_BW      = OUT_MSB,
    parameter int COEF      = COEF_Q15,
    parameter int N_SAMPLES = FRAME_LEN
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear_i,
    input  logic                 valid_i,
    input  logic signed [I_BW:0] data_i,
    output logic                 valid_o,
    output logic signed [O_BW:0] data_o,
    output logic                 sat_o,
    output logic                 last_o,
    output logic [15:0]          sat_cnt_o
);

    localparam int PW = O_BW + 18;
    localparam int CW = cnt_bits(N_SAMPLES);

    localparam logic signed [16:0] COEF_S   = 17'(COEF);
    localparam logic [CW-1:0]      LAST_IDX = CW'(N_SAMPLES - 1);

    state_t               state;
    logic signed [O_BW:0] y_prev;
    logic signed [O_BW:0] hist;
    logic signed [O_BW:0] res;
    logic [CW-1:0]        cnt;
    logic [CW-1:0]        cnt_cur;
    logic signed [PW-1:0] prod;
    logic                 fresh;
    logic                 sat;
    logic                 is_last;
    logic [15:0]          sat_base;

    // A sample is a frame start in IDLE or when clear_i arrives with it.
    assign fresh    = clear_i || (state == IDLE);
    assign hist     = fresh ? '0 : y_prev;
    assign cnt_cur  = fresh ? '0 : cnt;
    assign is_last  = (cnt_cur == LAST_IDX);
    assign sat_base = clear_i ? '0 : sat_cnt_o;
    assign prod     = PW'(hist) * PW'(COEF_S);

    sat_round #(
        .I_BW (I_BW),
        .O_BW (O_BW),
        .PW   (PW)
    ) u_sat (
        .prod   (prod),
        .data_i (data_i),
        .data_o (res),
        .sat_o  (sat)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            y_prev    <= '0;
            cnt       <= '0;
            valid_o   <= 1'b0;
            data_o    <= '0;
            sat_o     <= 1'b0;
            last_o    <= 1'b0;
            sat_cnt_o <= '0;
        end else begin
            valid_o <= valid_i;
            sat_o   <= 1'b0;
            last_o  <= 1'b0;
            if (valid_i) begin
                data_o <= res;
                sat_o  <= sat;
                last_o <= is_last;
                if (sat && sat_base != 16'hFFFF) begin
                    sat_cnt_o <= sat_base + 16'd1;
                end else begin
                    sat_cnt_o <= sat_base;
                end
                if (is_last) begin
                    state  <= IDLE;
                    y_prev <= '0;
                    cnt    <= '0;
                end else begin
                    state  <= RUN;
                    y_prev <= res;
                    cnt    <= cnt_cur + CW'(1);
                end
            end else if (clear_i) begin
                state     <= IDLE;
                y_prev    <= '0;
                cnt       <= '0;
                sat_cnt_o <= '0;
            end
        end
    end

endmodule

// File: tb/tb_deemphasis.sv
// Scoreboard bench for deemphasis: driver pushes reference results,
// a monitor pops and compares on every valid_o.
module tb_deemphasis;

    localparam int NS   = 4;
    localparam int COEF = 31785;

    typedef struct {
        int data;
        bit sat;
        bit last;
        int cnt;
    } exp_t;

    logic               clk = 1'b0;
    logic               rst;
    logic               clear_i;
    logic               valid_i;
    logic signed [16:0] data_i;
    logic               valid_o;
    logic signed [15:0] data_o;
    logic               sat_o;
    logic               last_o;
    logic [15:0]        sat_cnt_o;

    int   checks = 0;
    int   errors = 0;
    exp_t q[$];
    int   m_y;
    int   m_n;
    int   m_sc;

    always #5 clk = ~clk;

    deemphasis #(
        .N_SAMPLES (NS)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .clear_i   (clear_i),
        .valid_i   (valid_i),
        .data_i    (data_i),
        .valid_o   (valid_o),
        .data_o    (data_o),
        .sat_o     (sat_o),
        .last_o    (last_o),
        .sat_cnt_o (sat_cnt_o)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic void model_clear();
        m_y  = 0;
        m_n  = 0;
        m_sc = 0;
    endfunction

    // Reference: plain integer arithmetic on the filter equation.
    function automatic exp_t model(input int d, input bit clr);
        exp_t   e;
        longint p;
        int     s;
        if (clr) model_clear();
        p      = longint'(m_y) * COEF;
        s      = d + int'((p + 64'sd16384) >>> 15);
        e.sat  = (s > 32767) || (s < -32768);
        e.data = (s > 32767) ? 32767 : ((s < -32768) ? -32768 : s);
        e.last = (m_n == NS - 1);
        if (e.sat && m_sc < 65535) m_sc++;
        e.cnt = m_sc;
        if (e.last) begin
            m_y = 0;
            m_n = 0;
        end else begin
            m_y = e.data;
            m_n++;
        end
        return e;
    endfunction

    task automatic send(input bit v, input bit c, input int d,
                        input bit lit = 1'b0, input int want = 0);
        exp_t e;
        @(posedge clk);
        #2;
        rst     = 1'b0;
        valid_i = v;
        clear_i = c;
        data_i  = 17'(d);
        if (v) begin
            e = model(d, c);
            if (lit) e.data = want;
            q.push_back(e);
        end else if (c) begin
            model_clear();
        end
    endtask

    task automatic do_reset(input bit v, input int d);
        @(posedge clk);
        #2;
        rst     = 1'b1;
        valid_i = v;
        clear_i = 1'b0;
        data_i  = 17'(d);
        model_clear();
        @(posedge clk);
        #2;
        rst     = 1'b0;
        valid_i = 1'b0;
        chk("rst_valid_o", int'(valid_o), 0);
        chk("rst_data_o", int'(data_o), 0);
        chk("rst_sat_o", int'(sat_o), 0);
        chk("rst_last_o", int'(last_o), 0);
        chk("rst_sat_cnt_o", int'(sat_cnt_o), 0);
    endtask

    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (valid_o) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_valid: got data %0d expected no output",
                             data_o);
                end else begin
                    e = q.pop_front();
                    chk("data_o", int'(data_o), e.data);
                    chk("sat_o", int'(sat_o), int'(e.sat));
                    chk("last_o", int'(last_o), int'(e.last));
                    chk("sat_cnt_o", int'(sat_cnt_o), e.cnt);
                end
            end else if (q.size() != 0) begin
                e = q.pop_front();
                checks++;
                errors++;
                $display("FAIL missing_valid: got valid_o 0 expected output %0d",
                         e.data);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int r;
        bit v;
        bit c;
        int d;
        rst     = 1'b1;
        clear_i = 1'b0;
        valid_i = 1'b0;
        data_i  = '0;
        do_reset(1'b0, 0);

        // impulse response running into the frame boundary
        send(1, 0, 1000, 1, 1000);
        send(1, 0, 0, 1, 970);
        send(0, 0, 0);
        send(1, 0, 0, 1, 941);
        send(1, 0, 0, 1, 913);
        send(1, 0, 0, 1, 0);

        // round trip of pre-emphasized constant, with gaps
        do_reset(1'b0, 0);
        send(1, 0, 1000, 1, 1000);
        send(0, 0, 0);
        send(1, 0, 30, 1, 1000);
        send(1, 0, 30, 1, 1000);
        send(0, 0, 0);
        send(0, 0, 0);
        send(1, 0, 30, 1, 1000);

        // saturation in both directions
        do_reset(1'b0, 0);
        send(1, 0, 65535, 1, 32767);
        send(1, 0, 32767, 1, 32767);
        send(1, 0, -65536, 1, -32768);

        // clear with and without a sample
        do_reset(1'b0, 0);
        send(1, 0, 1000, 1, 1000);
        send(1, 0, 0, 1, 970);
        send(1, 1, 0, 1, 0);
        send(1, 0, 1000, 1, 1000);
        send(1, 0, 65535, 1, 32767);
        send(0, 1, 0);
        send(0, 0, 0);
        chk("clear_valid_o", int'(valid_o), 0);
        chk("clear_sat_cnt_o", int'(sat_cnt_o), 0);
        send(1, 0, 0, 1, 0);

        // reset mid-frame discards the sample in flight
        do_reset(1'b0, 0);
        send(1, 0, 1000, 1, 1000);
        do_reset(1'b1, 777);
        send(1, 0, 500, 1, 500);

        for (int i = 0; i < 600; i++) begin
            r = int'($urandom_range(0, 99));
            if (r < 2) begin
                do_reset(1'($urandom_range(0, 1)), 0);
            end else begin
                v = ($urandom_range(0, 99) < 75);
                c = ($urandom_range(0, 99) < 6);
                if ($urandom_range(0, 3) == 0) begin
                    d = int'($urandom_range(0, 131071)) - 65536;
                end else begin
                    d = int'($urandom_range(0, 4000)) - 2000;
                end
                send(v, c, d);
            end
        end

        send(0, 0, 0);
        send(0, 0, 0);
        send(0, 0, 0);
        chk("queue_drained", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/deemphasis.md
Name: deemphasis

Overview:
- Inverse of the pre-emphasis stage: the decoder side of the emphasis pair.
- Implements the first-order IIR y[n] = x[n] + a*y[n-1], with a = COEF/2^15 (Q15, default 0.97). It restores the flat spectrum from a pre-emphasized stream.
- Used in the verification and reconstruction path to round-trip pre-emphasis output back to 16-bit PCM.
- Frame-aware: filter history is cleared automatically after N_SAMPLES accepted samples, or on clear_i.

Parameters:
- I_BW, 16: MSB index of data_i. Input is I_BW+1 = 17 bits, signed, matching the pre-emphasis output.
- O_BW, 15: MSB index of data_o. Output is O_BW+1 = 16 bits, signed PCM.
- COEF, 31785: feedback coefficient in unsigned Q15 (0.97). Legal range 0..32767.
- N_SAMPLES, 16000: samples per frame. Must be ≥1.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  reset, synchronous, active-high.
- clear_i  in  1  clears filter history and frame counter; see Behaviour.
- valid_i  in  1  data_i carries a sample this cycle. No backpressure; a sample is accepted every valid cycle.
- data_i  in  I_BW+1  signed pre-emphasized sample.
- valid_o  out  1  data_o valid; registered.
- data_o  out  O_BW+1  signed de-emphasized sample, saturated.
- sat_o  out  1  with valid_o: this output was clipped.
- last_o  out  1  with valid_o: final sample of the frame.
- sat_cnt_o  out  16  number of clipped outputs since rst/clear_i; saturates at 65535.

Behaviour:
- Reset (rst=1 at a clk edge):
  - valid_o, sat_o, last_o, data_o, sat_cnt_o all = 0.
  - History y_prev = 0, sample counter = 0, state = IDLE.
  - rst overrides every other input.
- Latency: exactly 1 cycle. A sample accepted at edge k produces valid_o=1 after edge k, held for one cycle. valid_o is a 1-cycle pulse per sample.
- Idle cycles (valid_i=0): valid_o=0. data_o holds its last value. History and counter are unchanged.
- Arithmetic:
  - prod = y_prev (16b signed) * COEF (as positive 17b signed), 33b signed.
  - fb = (prod + 2^14) >>> 15, i.e. round half up, arithmetic shift.
  - sum = sign-extend(data_i, 18) + sign-extend(fb, 18).
  - data_o = sum clamped to [-2^O_BW, 2^O_BW-1]. sat_o=1 iff a clamp occurred.
  - y_prev takes the clamped value, never the unclamped sum.
- FSM, states IDLE and RUN:
  - IDLE: y_prev=0, counter=0. valid_i processes the sample with zero history. Next state is RUN, counter=1, unless N_SAMPLES=1.
  - RUN: each valid_i increments counter.
  - Sample with counter == N_SAMPLES-1: last_o=1 with its output. History and counter are cleared. Next state is IDLE.
- clear_i:
  - Same cycle as valid_i: the sample is processed as the first sample of a new frame (zero history, counter restarts at 1). sat_cnt_o restarts, counting this sample if it clipped.
  - Without valid_i: go to IDLE and zero history, counter and sat_cnt_o. valid_o=0.
- sat_cnt_o increments on each clipped output and holds at 65535.
- Behaviour with COEF outside 0..32767 is undefined.

Decomposition:
- Shared package emph_pkg holds:
  - Default COEF_Q15 = 31785 and Q = 15, shared with the pre-emphasis block so the pair stays inverse.
  - Default sample and frame widths.
  - FSM state enum {IDLE, RUN}.
- One natural sub-module: sat_round. It is combinational: takes prod and data_i, returns the clamped result and the sat flag. The pre-emphasis block can reuse it.

Test Plan:
- Impulse after reset: data_i = 1000, 0, 0 on consecutive valid cycles -> data_o = 1000, 970, 941. No sat_o. Each valid_o one cycle after its valid_i.
- Round trip: feed the pre-emphasized constant-1000 sequence 1000, 30, 30, 30 -> data_o = 1000, 1000, 1000, 1000 (±1 LSB). valid_i gaps between samples change nothing.
- Saturation: data_i = 65535 -> data_o = 32767, sat_o=1. Then data_i = 32767 -> 32767, sat_o=1, sat_cnt_o = 2. Then data_i = -65536 -> -32768, sat_o=1, sat_cnt_o = 3.
- Frame end with N_SAMPLES=4: feed 1000, 0, 0, 0, 0 -> last_o only on the 4th output (data_o = 913). The 5th output is 0 because history was cleared.
- clear_i: after 1000, 0, assert clear_i with valid_i and data_i = 0 -> data_o = 0, sat_cnt_o = 0. clear_i alone -> valid_o = 0, next sample sees zero history.
- Reset mid-frame: rst during RUN with valid_i=1 -> next cycle all outputs 0, sample discarded. First post-reset sample 500 -> data_o = 500.
